// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port data memory.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie (default: round-robin).
module dmem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          last_q;
  logic          gnt_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          busy_q;
  logic          en_q;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          win_d;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win_d = ~req0;
`else
  // on a tie the port that did not own the previous grant wins
  assign win_d = (req0 & req1) ? ~last_q : req1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            state_q <= ACCESS;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            gnt_q   <= win_d;
            last_q  <= win_d;
            rw_q    <= win_d ? rw1 : rw0;
            addr_q  <= win_d ? addr1 : addr0;
            wdata_q <= win_d ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          en_q <= 1'b0;
          if (rw_q) begin
            state_q <= RESP;
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q <= RESP;
            rdata_q <= mem_data_out;
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign mem_en      = en_q;
  assign mem_rw      = rw_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign busy        = busy_q;
  assign gnt_id      = gnt_q;

endmodule
